// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two valid/ready requesters, one transaction in flight.
// Define ALU_ARB_PRIO_EN for fixed priority (r0 wins ties); default is round-robin.
module alu_share_arb #(
  parameter int DW  = 32,
  parameter int SHW = 4,
  parameter int CW  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           r0_valid,
  output logic           r0_ready,
  input  logic [DW-1:0]  r0_srca,
  input  logic [DW-1:0]  r0_srcb,
  input  logic [SHW-1:0] r0_shift,
  input  logic [CW-1:0]  r0_ctrl,
  output logic           r0_rvalid,
  input  logic           r0_rready,
  output logic [DW-1:0]  r0_res,
  output logic           r0_zero,
  input  logic           r1_valid,
  output logic           r1_ready,
  input  logic [DW-1:0]  r1_srca,
  input  logic [DW-1:0]  r1_srcb,
  input  logic [SHW-1:0] r1_shift,
  input  logic [CW-1:0]  r1_ctrl,
  output logic           r1_rvalid,
  input  logic           r1_rready,
  output logic [DW-1:0]  r1_res,
  output logic           r1_zero,
  output logic [DW-1:0]  alu_srca,
  output logic [DW-1:0]  alu_srcb,
  output logic [SHW-1:0] alu_shift,
  output logic [CW-1:0]  alu_ctrl,
  input  logic [DW-1:0]  alu_res,
  input  logic           alu_zero
);

  // state | meaning
  // ARB   | waiting for a request; winner gets ready this cycle
  // EXEC  | ALU driven from latched operands; result captured
  // RESP  | owner's response held until rready
  typedef enum logic [1:0] {ARB, EXEC, RESP} state_t;

  state_t         state, state_nxt;
  logic [DW-1:0]  op_srca, op_srcb;
  logic [SHW-1:0] op_shift;
  logic [CW-1:0]  op_ctrl;
  logic           owner;
  logic [DW-1:0]  resp_res;
  logic           resp_zero;
  logic           rvalid_q;
  logic           gnt_any, gnt_id, grant, resp_taken;
`ifndef ALU_ARB_PRIO_EN
  logic           last_gnt;
`endif

  always_comb begin
    gnt_any = r0_valid | r1_valid;
`ifdef ALU_ARB_PRIO_EN
    gnt_id = ~r0_valid;
`else
    gnt_id = (r0_valid & r1_valid) ? ~last_gnt : r1_valid;
`endif
  end

  assign grant      = (state == ARB) && gnt_any;
  assign resp_taken = (state == RESP) && (owner ? r1_rready : r0_rready);

  always_comb begin
    state_nxt = state;
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    case (state)
      ARB: begin
        // gated by rst so ready reads 0 while reset is held with valid high
        if (gnt_any && !rst) begin
          r0_ready  = ~gnt_id;
          r1_ready  = gnt_id;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_taken) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB;
      op_srca   <= '0;
      op_srcb   <= '0;
      op_shift  <= '0;
      op_ctrl   <= '0;
      owner     <= 1'b0;
      resp_res  <= '0;
      resp_zero <= 1'b0;
      rvalid_q  <= 1'b0;
`ifndef ALU_ARB_PRIO_EN
      last_gnt  <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (grant) begin
        op_srca  <= gnt_id ? r1_srca  : r0_srca;
        op_srcb  <= gnt_id ? r1_srcb  : r0_srcb;
        op_shift <= gnt_id ? r1_shift : r0_shift;
        op_ctrl  <= gnt_id ? r1_ctrl  : r0_ctrl;
        owner    <= gnt_id;
`ifndef ALU_ARB_PRIO_EN
        last_gnt <= gnt_id;
`endif
      end
      if (state == EXEC) begin
        resp_res  <= alu_res;
        resp_zero <= alu_zero;
        rvalid_q  <= 1'b1;
      end else if (resp_taken) begin
        rvalid_q  <= 1'b0;
      end
    end
  end

  assign alu_srca  = op_srca;
  assign alu_srcb  = op_srcb;
  assign alu_shift = op_shift;
  assign alu_ctrl  = op_ctrl;

  assign r0_rvalid = rvalid_q & ~owner;
  assign r1_rvalid = rvalid_q & owner;
  assign r0_res    = resp_res;
  assign r1_res    = resp_res;
  assign r0_zero   = resp_zero;
  assign r1_zero   = resp_zero;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU attached to the alu_* ports.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_ready, r0_rvalid, r0_rready, r0_zero;
  logic [31:0] r0_srca, r0_srcb, r0_res;
  logic [3:0]  r0_shift;
  logic [2:0]  r0_ctrl;
  logic        r1_valid, r1_ready, r1_rvalid, r1_rready, r1_zero;
  logic [31:0] r1_srca, r1_srcb, r1_res;
  logic [3:0]  r1_shift;
  logic [2:0]  r1_ctrl;
  logic [31:0] alu_srca, alu_srcb, alu_res;
  logic [3:0]  alu_shift;
  logic [2:0]  alu_ctrl;
  logic        alu_zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_srca(r0_srca), .r0_srcb(r0_srcb),
    .r0_shift(r0_shift), .r0_ctrl(r0_ctrl), .r0_rvalid(r0_rvalid), .r0_rready(r0_rready),
    .r0_res(r0_res), .r0_zero(r0_zero),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_srca(r1_srca), .r1_srcb(r1_srcb),
    .r1_shift(r1_shift), .r1_ctrl(r1_ctrl), .r1_rvalid(r1_rvalid), .r1_rready(r1_rready),
    .r1_res(r1_res), .r1_zero(r1_zero),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_shift(alu_shift), .alu_ctrl(alu_ctrl),
    .alu_res(alu_res), .alu_zero(alu_zero)
  );

  // behavioural ALU; ROT is rotate-left, zero only reported for SUB
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      3'b000: alu_res = alu_srca + alu_srcb;
      3'b001: alu_res = alu_srca | alu_srcb;
      3'b010: alu_res = alu_srca & alu_srcb;
      3'b011: alu_res = alu_srca ^ alu_srcb;
      3'b100: alu_res = ~(alu_srca | alu_srcb);
      3'b101: alu_res = alu_srca << alu_shift;
      3'b110: alu_res = (alu_srca << alu_shift) | (alu_srca >> (6'd32 - {2'b0, alu_shift}));
      default: alu_res = alu_srca - alu_srcb;
    endcase
    alu_zero = (alu_ctrl == 3'b111) && (alu_res == '0);
  end

  typedef struct {
    logic        port;
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sh;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  waited;
    logic seen;
    @(negedge clk);
    if (v.port) begin
      r1_valid = 1'b1; r1_srca = v.a; r1_srcb = v.b; r1_shift = v.sh; r1_ctrl = v.ctrl;
    end else begin
      r0_valid = 1'b1; r0_srca = v.a; r0_srcb = v.b; r0_shift = v.sh; r0_ctrl = v.ctrl;
    end
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 10) begin
      #1;
      seen = v.port ? r1_ready : r0_ready;
      if (!seen) begin
        @(negedge clk);
        waited++;
      end
    end
    check("vec_ready", {31'b0, seen}, 32'd1);
    check("vec_other_ready", {31'b0, v.port ? r0_ready : r1_ready}, 32'd0);
    @(negedge clk);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    check("vec_exec_rvalid", {30'b0, r1_rvalid, r0_rvalid}, 32'd0);
    @(negedge clk);
    check("vec_rvalid", {30'b0, r1_rvalid, r0_rvalid}, v.port ? 32'd2 : 32'd1);
    check("vec_res", v.port ? r1_res : r0_res, v.res);
    check("vec_zero", {31'b0, v.port ? r1_zero : r0_zero}, {31'b0, v.zero});
  endtask

  initial begin
    int gnt_cyc[8];
    int gnt_id[8];
    int ngnt;
    int ncyc;

    vecs[0] = '{1'b0, 3'b000, 32'd5,        32'd7,        4'd0, 32'd12,       1'b0};
    vecs[1] = '{1'b1, 3'b111, 32'd9,        32'd9,        4'd0, 32'd0,        1'b1};
    vecs[2] = '{1'b1, 3'b101, 32'd1,        32'd0,        4'd4, 32'd16,       1'b0};
    vecs[3] = '{1'b0, 3'b010, 32'hF0F0,     32'hFF00,     4'd0, 32'hF000,     1'b0};
    vecs[4] = '{1'b0, 3'b110, 32'h80000001, 32'd0,        4'd1, 32'h3,        1'b0};
    vecs[5] = '{1'b1, 3'b011, 32'hA5,       32'hFF,       4'd0, 32'h5A,       1'b0};
    vecs[6] = '{1'b0, 3'b100, 32'd0,        32'd0,        4'd0, 32'hFFFFFFFF, 1'b0};
    vecs[7] = '{1'b0, 3'b111, 32'd3,        32'd5,        4'd0, 32'hFFFFFFFE, 1'b0};
    vecs[8] = '{1'b1, 3'b000, 32'hFFFFFFFF, 32'd1,        4'd0, 32'd0,        1'b0};

    rst = 1'b1;
    r0_valid = 0; r0_srca = 0; r0_srcb = 0; r0_shift = 0; r0_ctrl = 0; r0_rready = 1;
    r1_valid = 0; r1_srca = 0; r1_srcb = 0; r1_shift = 0; r1_ctrl = 0; r1_rready = 1;
    repeat (2) @(negedge clk);
    check("rst_ready", {30'b0, r1_ready, r0_ready}, 32'd0);
    check("rst_rvalid", {30'b0, r1_rvalid, r0_rvalid}, 32'd0);
    check("rst_res", r0_res, 32'd0);
    check("rst_alu", {alu_srca ^ alu_srcb, 25'b0, alu_shift, alu_ctrl} | {25'b0, alu_shift, alu_ctrl}, 32'd0);
    check("rst_alu_srca", alu_srca, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // both requesters permanently valid
    @(negedge clk);
    r0_valid = 1; r0_srca = 32'd10; r0_srcb = 32'd1; r0_ctrl = 3'b000; r0_shift = 0;
    r1_valid = 1; r1_srca = 32'd20; r1_srcb = 32'd2; r1_ctrl = 3'b000; r1_shift = 0;
    ngnt = 0;
`ifdef ALU_ARB_PRIO_EN
    ncyc = 12;
`else
    ncyc = 18;
`endif
    for (int c = 0; c < ncyc; c++) begin
      #1;
      if ((r0_ready || r1_ready) && ngnt < 8) begin
        gnt_cyc[ngnt] = c;
        gnt_id[ngnt] = r1_ready ? 1 : 0;
        ngnt++;
      end
      if (r0_rvalid) check("both_r0_res", r0_res, 32'd11);
      if (r1_rvalid) check("both_r1_res", r1_res, 32'd22);
      @(negedge clk);
    end
    check("both_ngrant", ngnt, ncyc / 3);
    for (int k = 0; k < ngnt && k < 8; k++) begin
`ifdef ALU_ARB_PRIO_EN
      check("both_order", gnt_id[k], 32'd0);
`else
      check("both_order", gnt_id[k], k % 2);
`endif
      check("both_spacing", gnt_cyc[k], 3 * k);
    end
`ifdef ALU_ARB_PRIO_EN
    r0_valid = 0;
    #1;
    check("prio_r1_after_drop", {30'b0, r1_ready, r0_ready}, 32'd2);
    @(negedge clk);
    r1_valid = 0;
    @(negedge clk);
    check("prio_r1_res", r1_res, 32'd22);
`else
    r0_valid = 0;
    r1_valid = 0;
`endif

    // held response with backpressure, r1 pending behind it
    @(negedge clk);
    r0_valid = 1; r0_srca = 32'hF0; r0_srcb = 32'h0F; r0_ctrl = 3'b001; r0_rready = 0;
    #1;
    check("bp_r0_ready", {31'b0, r0_ready}, 32'd1);
    @(negedge clk);
    r0_valid = 0;
    r1_valid = 1; r1_srca = 32'd1; r1_srcb = 32'd2; r1_ctrl = 3'b000;
    #1;
    check("bp_exec_ready", {30'b0, r1_ready, r0_ready}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_rvalid", {30'b0, r1_rvalid, r0_rvalid}, 32'd1);
      check("bp_res", r0_res, 32'hFF);
      check("bp_ready", {30'b0, r1_ready, r0_ready}, 32'd0);
    end
    r0_rready = 1;
    #1;
    check("bp_no_accept_in_resp", {30'b0, r1_ready, r0_ready}, 32'd0);
    @(negedge clk);
    #1;
    check("bp_r1_granted", {30'b0, r1_ready, r0_ready}, 32'd2);
    check("bp_rvalid_clear", {30'b0, r1_rvalid, r0_rvalid}, 32'd0);
    @(negedge clk);
    r1_valid = 0;
    @(negedge clk);
    check("bp_r1_rvalid", {30'b0, r1_rvalid, r0_rvalid}, 32'd2);
    check("bp_r1_res", r1_res, 32'd3);

    // reset while an op is in EXEC
    @(negedge clk);
    r0_valid = 1; r0_srca = 32'd4; r0_srcb = 32'd4; r0_ctrl = 3'b000;
    #1;
    check("rx_ready", {31'b0, r0_ready}, 32'd1);
    @(negedge clk);
    r0_valid = 0;
    rst = 1;
    #1;
    check("rx_rvalid", {30'b0, r1_rvalid, r0_rvalid}, 32'd0);
    check("rx_res", r0_res, 32'd0);
    check("rx_zero", {31'b0, r0_zero}, 32'd0);
    check("rx_alu_srca", alu_srca, 32'd0);
    check("rx_alu_ctrl", {29'b0, alu_ctrl}, 32'd0);
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rx_no_resp", {30'b0, r1_rvalid, r0_rvalid}, 32'd0);
    end
    r0_valid = 1; r1_valid = 1;
    #1;
    check("rx_first_grant", {30'b0, r1_ready, r0_ready}, 32'd1);
    @(negedge clk);
    r0_valid = 0; r1_valid = 0;
    @(negedge clk);
    check("rx_resp", r0_res, 32'd8);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
